dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port, word-addressed data memory (1024 x 32, synchronous read and write).
- Port 0 is the CPU load/store stage. Port 1 is a secondary master (program loader, debug or DMA).
- Serializes accesses, drives the memory's mem_read/mem_write/address/data_write, and returns read data with a valid strobe.
- Blocks out-of-range addresses before they reach the memory.

Parameters:
- DEPTH, 1024: number of memory words; addresses >= DEPTH are errors.
- DATA_W, 32: data width.
- RR_MODE, 0: 0 = fixed priority (port 0 wins, with starvation guard); 1 = round-robin.
- STARVE_LIMIT, 8: in fixed-priority mode, cycles port 1 may wait before a forced grant. Range 1..255.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pN_req (N=0,1)  input  1  access request; held until pN_gnt is seen.
- pN_we  input  1  1 = store, 0 = load; held with req.
- pN_addr  input  32  word address; held with req.
- pN_wdata  input  DATA_W  store data; held with req.
- pN_gnt  output  1  one-cycle pulse: access issued (or rejected, see err).
- pN_rvalid  output  1  one-cycle pulse: pN_rdata valid.
- pN_rdata  output  DATA_W  load data; 0 when rvalid is low.
- pN_err  output  1  pulses with gnt when addr >= DEPTH.
- mem_read  output  1  to memory read enable.
- mem_write  output  1  to memory write enable.
- mem_address  output  32  to memory address.
- mem_data_write  output  DATA_W  to memory write data.
- mem_data_read  input  DATA_W  from memory; valid the cycle after mem_read was sampled.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE. All outputs are 0. The RR pointer favours port 0 and the starvation counter is cleared.
  - Reset during ISSUE or RESP aborts the access; no gnt or rvalid is produced for it.
  - After rst_n rises, the first decision is made in the next IDLE cycle.
- FSM states: IDLE, ISSUE, RESP. All outputs are registered except pN_rdata, which is a gated pass-through of mem_data_read during RESP.
- Arbitration happens in IDLE and in RESP, and only when some req is high.
  - The winner's we/addr/wdata are latched at the edge and the FSM goes to ISSUE.
  - With no req: RESP goes to IDLE, and IDLE stays IDLE.
- ISSUE (1 cycle):
  - Winner's gnt is 1.
  - In-range store: mem_write=1. In-range load: mem_read=1. mem_address and mem_data_write carry the latched values.
  - Next state: RESP for a load (including a rejected load), IDLE for a store.
- RESP (1 cycle): winner's rvalid is 1.
  - rdata = mem_data_read for an in-range load, 0 for a rejected load.
  - The next grant can be decided in this same cycle, so back-to-back loads run every 2 cycles.
- Latency, from req sampled in IDLE at edge E:
  - gnt and memory strobe during cycle E+1.
  - Load rvalid during cycle E+2.
  - Store complete in memory at edge E+2.
- Out-of-range (addr >= DEPTH): mem_read and mem_write stay 0; err pulses with gnt; a load still returns rvalid with rdata = 0.
- Fixed priority (RR_MODE=0):
  - Port 0 wins simultaneous requests.
  - The counter increments each cycle port 1 req=1 and port 1 is not granted; it saturates at STARVE_LIMIT.
  - When counter == STARVE_LIMIT, the next decision goes to port 1 even if port 0 requests.
  - The counter clears when port 1 is granted.
- Round-robin (RR_MODE=1): on a simultaneous request the port not granted last wins. The pointer updates on every grant.
- Only one gnt or rvalid is high per cycle; the memory never sees mem_read and mem_write together.

Test Plan:
- Store then load, port 0: store addr 5 data 0xDEADBEEF; once the store's gnt has been seen, load addr 5 → gnt 1 cycle after each req; load rvalid 2 cycles after its req with p0_rdata = 0xDEADBEEF; p1 outputs stay 0.
- Simultaneous loads, RR_MODE=0: both ports load continuously → port 0 granted; port 1 granted after exactly STARVE_LIMIT=8 waiting cycles; the counter then restarts.
- Simultaneous loads, RR_MODE=1: both ports load continuously → grants alternate 0,1,0,1; back-to-back loads produce rvalid every 2 cycles.
- Out of range: p1 load addr 1024 → p1_gnt and p1_err together; mem_read stays 0; p1_rvalid next cycle with rdata = 0. p1 store addr 0xFFFFFFFF → err; mem_write never asserted.
- Reset mid-access: assert rst_n=0 during the ISSUE cycle of a load → all outputs 0 immediately; no rvalid after reset release; the next request is serviced normally with port 0 priority.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-port arbiter and sequencer in front of a single-port synchronous data memory.
// Serializes loads/stores, blocks out-of-range addresses and returns load data with a valid strobe.
//
// state | meaning
// IDLE  | no access in flight; arbitrate when any request is high
// ISSUE | grant pulse and memory strobe for the latched access
// RESP  | load data returned to the winner; next grant may be decided here
module dm_arbiter #(
    parameter int DEPTH        = 1024,
    parameter int DATA_W       = 32,
    parameter int RR_MODE      = 0,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [31:0]       p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [31:0]       p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    input  logic [DATA_W-1:0] mem_data_read,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]        r_state;
    logic              r_sel;
    logic              r_we;
    logic              r_oor;
    logic              r_rr_last;
    logic [7:0]        r_starve;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_err0;
    logic              r_err1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [31:0]       r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_decide;
    logic              w_sel;
    logic              w_we;
    logic [31:0]       w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_in_range;
    logic              w_p1_issuing;

    assign w_decide = (r_state == S_IDLE || r_state == S_RESP) && (p0_req || p1_req);

    always_comb begin
        w_sel = p1_req;
        if (p0_req && p1_req) begin
            if (RR_MODE != 0)
                w_sel = ~r_rr_last;
            else
                w_sel = (r_starve == 8'(STARVE_LIMIT));
        end
    end

    assign w_we       = w_sel ? p1_we    : p0_we;
    assign w_addr     = w_sel ? p1_addr  : p0_addr;
    assign w_wdata    = w_sel ? p1_wdata : p0_wdata;
    assign w_in_range = (w_addr < 32'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sel       <= 1'b0;
            r_we        <= 1'b0;
            r_oor       <= 1'b0;
            r_rr_last   <= 1'b1;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_decide) begin
                        r_state     <= S_ISSUE;
                        r_sel       <= w_sel;
                        r_we        <= w_we;
                        r_oor       <= ~w_in_range;
                        r_rr_last   <= w_sel;
                        r_gnt0      <= ~w_sel;
                        r_gnt1      <= w_sel;
                        r_err0      <= ~w_sel & ~w_in_range;
                        r_err1      <= w_sel & ~w_in_range;
                        r_mem_read  <= ~w_we & w_in_range;
                        r_mem_write <= w_we & w_in_range;
                        // Out-of-range addresses never reach the memory bus.
                        if (w_in_range) begin
                            r_mem_addr  <= w_addr;
                            r_mem_wdata <= w_wdata;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (!r_we) begin
                        r_state   <= S_RESP;
                        r_rvalid0 <= ~r_sel;
                        r_rvalid1 <= r_sel;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Port 1's own grant cycle does not count as waiting.
    assign w_p1_issuing = (r_state == S_ISSUE) && r_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (RR_MODE != 0) begin
            r_starve <= '0;
        end else if (w_decide && w_sel) begin
            r_starve <= '0;
        end else if (p1_req && !w_p1_issuing && r_starve != 8'(STARVE_LIMIT)) begin
            r_starve <= r_starve + 8'd1;
        end
    end

    assign p0_gnt         = r_gnt0;
    assign p1_gnt         = r_gnt1;
    assign p0_err         = r_err0;
    assign p1_err         = r_err1;
    assign p0_rvalid      = r_rvalid0;
    assign p1_rvalid      = r_rvalid1;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_address    = r_mem_addr;
    assign mem_data_write = r_mem_wdata;
    assign busy           = (r_state != S_IDLE);

    assign p0_rdata = (r_state == S_RESP && !r_sel && !r_oor) ? mem_data_read : '0;
    assign p1_rdata = (r_state == S_RESP &&  r_sel && !r_oor) ? mem_data_read : '0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: one fixed-priority instance and one round-robin instance,
// each backed by a small synchronous memory model.
module tb_dm_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic        a0_req, a0_we, a0_gnt, a0_rvalid, a0_err;
    logic [31:0] a0_addr, a0_wdata, a0_rdata;
    logic        a1_req, a1_we, a1_gnt, a1_rvalid, a1_err;
    logic [31:0] a1_addr, a1_wdata, a1_rdata;
    logic        a_mem_read, a_mem_write, a_busy;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b0_req, b0_we, b0_gnt, b0_rvalid, b0_err;
    logic [31:0] b0_addr, b0_wdata, b0_rdata;
    logic        b1_req, b1_we, b1_gnt, b1_rvalid, b1_err;
    logic [31:0] b1_addr, b1_wdata, b1_rdata;
    logic        b_mem_read, b_mem_write, b_busy;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];

    dm_arbiter #(.DEPTH(1024), .DATA_W(32), .RR_MODE(0), .STARVE_LIMIT(8)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req(a0_req), .p0_we(a0_we), .p0_addr(a0_addr), .p0_wdata(a0_wdata),
        .p0_gnt(a0_gnt), .p0_rvalid(a0_rvalid), .p0_rdata(a0_rdata), .p0_err(a0_err),
        .p1_req(a1_req), .p1_we(a1_we), .p1_addr(a1_addr), .p1_wdata(a1_wdata),
        .p1_gnt(a1_gnt), .p1_rvalid(a1_rvalid), .p1_rdata(a1_rdata), .p1_err(a1_err),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_address(a_mem_addr),
        .mem_data_write(a_mem_wdata), .mem_data_read(a_mem_rdata), .busy(a_busy)
    );

    dm_arbiter #(.DEPTH(1024), .DATA_W(32), .RR_MODE(1), .STARVE_LIMIT(8)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .p0_req(b0_req), .p0_we(b0_we), .p0_addr(b0_addr), .p0_wdata(b0_wdata),
        .p0_gnt(b0_gnt), .p0_rvalid(b0_rvalid), .p0_rdata(b0_rdata), .p0_err(b0_err),
        .p1_req(b1_req), .p1_we(b1_we), .p1_addr(b1_addr), .p1_wdata(b1_wdata),
        .p1_gnt(b1_gnt), .p1_rvalid(b1_rvalid), .p1_rdata(b1_rdata), .p1_err(b1_err),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_address(b_mem_addr),
        .mem_data_write(b_mem_wdata), .mem_data_read(b_mem_rdata), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_mem_write) mem_a[a_mem_addr[9:0]] <= a_mem_wdata;
        if (a_mem_read)  a_mem_rdata <= mem_a[a_mem_addr[9:0]];
        if (b_mem_write) mem_b[b_mem_addr[9:0]] <= b_mem_wdata;
        if (b_mem_read)  b_mem_rdata <= mem_b[b_mem_addr[9:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        logic [1:0] exp_g;
        logic [1:0] prev_g;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 32'hA5A50000 ^ i;
            mem_b[i] = 32'(i * 3);
        end
        a_mem_rdata = '0;
        b_mem_rdata = '0;
        rst_n = 1'b0;
        {a0_req, a0_we, a1_req, a1_we, b0_req, b0_we, b1_req, b1_we} = '0;
        {a0_addr, a0_wdata, a1_addr, a1_wdata} = '0;
        {b0_addr, b0_wdata, b1_addr, b1_wdata} = '0;
        prev_g = 2'b00;

        step();
        check("reset_ctrl_fp", 64'({a0_gnt, a1_gnt, a0_rvalid, a1_rvalid, a0_err, a1_err,
                                    a_mem_read, a_mem_write, a_busy}), 64'd0);
        check("reset_bus_fp", {a_mem_addr, a_mem_wdata}, 64'd0);
        check("reset_rdata_fp", {a0_rdata, a1_rdata}, 64'd0);
        check("reset_ctrl_rr", 64'({b0_gnt, b1_gnt, b0_rvalid, b1_rvalid, b_busy}), 64'd0);
        rst_n = 1'b1;
        step();

        // Store 0xDEADBEEF to word 5 on port 0, then load it back.
        a0_req = 1'b1; a0_we = 1'b1; a0_addr = 32'd5; a0_wdata = 32'hDEADBEEF;
        step();
        check("st_gnt", 64'({a0_gnt, a1_gnt, a0_err, a_mem_write, a_mem_read, a_busy}), 64'b100101);
        check("st_bus", {a_mem_addr, a_mem_wdata}, {32'd5, 32'hDEADBEEF});
        a0_req = 1'b0; a0_we = 1'b0;
        step();
        check("st_done", 64'({a0_gnt, a_mem_write, a_busy}), 64'd0);
        a0_req = 1'b1; a0_we = 1'b0; a0_addr = 32'd5;
        step();
        check("ld_gnt", 64'({a0_gnt, a1_gnt, a_mem_read, a_mem_write, a0_rvalid}), 64'b10100);
        check("ld_addr", 64'(a_mem_addr), 64'd5);
        a0_req = 1'b0;
        step();
        check("ld_rvalid", 64'({a0_rvalid, a1_rvalid, a0_gnt, a_busy}), 64'b1001);
        check("ld_rdata", {a0_rdata, a1_rdata}, {32'hDEADBEEF, 32'd0});
        check("ld_p1_quiet", 64'({a1_gnt, a1_rvalid, a1_err}), 64'd0);
        step();
        check("ld_idle", 64'({a0_rvalid, a_busy, a_mem_read}), 64'd0);
        check("ld_rdata_gated", 64'(a0_rdata), 64'd0);

        // Out-of-range load and store on port 1.
        a1_req = 1'b1; a1_we = 1'b0; a1_addr = 32'd1024;
        step();
        check("oor_ld_gnt", 64'({a1_gnt, a1_err, a0_gnt, a0_err, a_mem_read, a_mem_write}), 64'b110000);
        a1_req = 1'b0;
        step();
        check("oor_ld_rvalid", 64'({a1_rvalid, a1_err, a_mem_read}), 64'b100);
        check("oor_ld_rdata", 64'(a1_rdata), 64'd0);
        step();
        a1_req = 1'b1; a1_we = 1'b1; a1_addr = 32'hFFFFFFFF; a1_wdata = 32'h12345678;
        step();
        check("oor_st_gnt", 64'({a1_gnt, a1_err, a_mem_write, a_mem_read}), 64'b1100);
        a1_req = 1'b0; a1_we = 1'b0;
        step();
        check("oor_st_done", 64'({a1_rvalid, a_mem_write, a_busy}), 64'd0);

        // Fixed priority with both ports loading continuously: p0 x4 then forced p1.
        a0_req = 1'b1; a0_addr = 32'd5;
        a1_req = 1'b1; a1_addr = 32'd6;
        for (int i = 1; i <= 20; i++) begin
            step();
            exp_g = ((i % 2) == 1) ? ((((i - 1) / 2) % 5 == 4) ? 2'b10 : 2'b01) : 2'b00;
            check($sformatf("fp_gnt_c%0d", i), 64'({a1_gnt, a0_gnt}), 64'(exp_g));
            check($sformatf("fp_rvalid_c%0d", i), 64'({a1_rvalid, a0_rvalid}), 64'(prev_g));
            if (prev_g == 2'b01)
                check($sformatf("fp_rdata_c%0d", i), {a1_rdata, a0_rdata}, {32'd0, 32'hDEADBEEF});
            else if (prev_g == 2'b10)
                check($sformatf("fp_rdata_c%0d", i), {a1_rdata, a0_rdata}, {32'hA5A50006, 32'd0});
            check($sformatf("fp_rw_excl_c%0d", i), 64'(a_mem_read & a_mem_write), 64'd0);
            prev_g = exp_g;
        end
        a0_req = 1'b0; a1_req = 1'b0;
        step();
        step();
        check("fp_drain", 64'({a_busy, a0_rvalid, a1_rvalid}), 64'd0);

        // Round-robin with both ports loading continuously: 0,1,0,1.
        b0_req = 1'b1; b0_addr = 32'd7;
        b1_req = 1'b1; b1_addr = 32'd9;
        prev_g = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_g = ((i % 2) == 1) ? ((((i - 1) / 2) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            check($sformatf("rr_gnt_c%0d", i), 64'({b1_gnt, b0_gnt}), 64'(exp_g));
            check($sformatf("rr_rvalid_c%0d", i), 64'({b1_rvalid, b0_rvalid}), 64'(prev_g));
            if (prev_g == 2'b01)
                check($sformatf("rr_rdata_c%0d", i), {b1_rdata, b0_rdata}, {32'd0, 32'd21});
            else if (prev_g == 2'b10)
                check($sformatf("rr_rdata_c%0d", i), {b1_rdata, b0_rdata}, {32'd27, 32'd0});
            prev_g = exp_g;
        end
        b0_req = 1'b0; b1_req = 1'b0;
        step();
        step();

        // Reset asserted during the ISSUE cycle of a load.
        a0_req = 1'b1; a0_we = 1'b0; a0_addr = 32'd5;
        step();
        check("rst_pre_gnt", 64'({a0_gnt, a_mem_read}), 64'b11);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", 64'({a0_gnt, a1_gnt, a_mem_read, a_mem_write, a_busy,
                                      a0_rvalid, a0_err}), 64'd0);
        check("rst_async_bus", {a_mem_addr, a_mem_wdata}, 64'd0);
        a0_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rst_no_rvalid", 64'({a0_rvalid, a1_rvalid, a_busy}), 64'd0);
        a0_req = 1'b1; a0_addr = 32'd5;
        a1_req = 1'b1; a1_we = 1'b0; a1_addr = 32'd6;
        step();
        check("rst_next_gnt", 64'({a1_gnt, a0_gnt}), 64'b01);
        a0_req = 1'b0; a1_req = 1'b0;
        step();
        check("rst_next_rvalid", 64'({a1_rvalid, a0_rvalid}), 64'b01);
        check("rst_next_rdata", 64'(a0_rdata), 64'hDEADBEEF);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
